// File: rtl/axi_pkg.sv
// Shared AXI response/burst codes, FSM state types and burst context for the SRAM slave.
package axi_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_LEN_W  = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  // Latched per-burst context, one copy per direction.
  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_LEN_W-1:0]  len;
    logic [AXI_LEN_W-1:0]  cnt;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [1:0]            resp;
  } burst_t;

  // Response decided once at the address handshake; DECERR outranks SLVERR.
  function automatic logic [1:0] start_resp(input logic hit, input logic [2:0] size,
                                            input logic [1:0] burst);
    logic [1:0] r;
    r = RESP_OKAY;
    if (size > 3'd2 || (burst != BURST_FIXED && burst != BURST_INCR)) r = RESP_SLVERR;
    if (!hit) r = RESP_DECERR;
    return r;
  endfunction

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Next beat address for FIXED and INCR bursts; WRAP and reserved types advance as INCR.
module axi_addr_gen
  import axi_pkg::*;
(
  input  logic [AXI_ADDR_W-1:0] addr,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [AXI_ADDR_W-1:0] next_addr_c
);

  always_comb begin
    next_addr_c = addr;
    if (burst != BURST_FIXED) next_addr_c = addr + (AXI_ADDR_W'(1) << size);
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave mapping a BASE-relative window onto a single-port SRAM.
// Read and write FSMs run concurrently; write beats own the SRAM port.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [3:0]        awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [3:0]        wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              sram_en,
  output logic [3:0]        sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  r_state_e    r_state_q, r_state_d;
  w_state_e    w_state_q, w_state_d;
  burst_t      r_q, w_q;
  logic        r_fresh_q;
  logic [31:0] r_data_q;
  logic [31:0] r_next_c, w_next_c;
  logic        ar_hit_c, aw_hit_c;
  logic        r_last_c, w_last_c, w_beat_c, w_sram_c, r_sram_c;
  logic [1:0]  w_beat_resp_c;
  logic        unused_sideband;

  assign unused_sideband = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

  assign ar_hit_c      = ((araddr - BASE) >> (ADDR_W + 2)) == 32'd0;
  assign aw_hit_c      = ((awaddr - BASE) >> (ADDR_W + 2)) == 32'd0;
  assign r_last_c      = r_q.cnt == r_q.len;
  assign w_last_c      = w_q.cnt == w_q.len;
  assign w_beat_c      = (w_state_q == W_DATA) && wvalid;
  assign w_beat_resp_c = (wlast != w_last_c) ? RESP_SLVERR : RESP_OKAY;
  assign w_sram_c      = w_beat_c && (w_q.resp != RESP_DECERR);
  assign r_sram_c      = (r_state_q == R_ISSUE) && !w_beat_c && (r_q.resp != RESP_DECERR);

  axi_addr_gen u_r_addr_gen (.addr(r_q.addr), .size(r_q.size), .burst(r_q.burst), .next_addr_c(r_next_c));
  axi_addr_gen u_w_addr_gen (.addr(w_q.addr), .size(w_q.size), .burst(w_q.burst), .next_addr_c(w_next_c));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
    end
  end

  // Read issue holds off while a write beat occupies the SRAM port.
  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE:  if (arvalid) r_state_d = R_ISSUE;
      R_ISSUE: if (!w_beat_c) r_state_d = R_DATA;
      R_DATA:  if (rready) r_state_d = r_last_c ? R_IDLE : R_ISSUE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      W_IDLE:  if (awvalid) w_state_d = W_DATA;
      W_DATA:  if (w_beat_c && w_last_c) w_state_d = W_RESP;
      W_RESP:  if (bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read context; r_data_q keeps the beat once the SRAM output has been sampled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_q       <= '0;
      r_fresh_q <= 1'b0;
      r_data_q  <= '0;
    end else begin
      r_fresh_q <= (r_state_q == R_ISSUE) && !w_beat_c;
      if (r_fresh_q) r_data_q <= sram_rdata;
      if (r_state_q == R_IDLE && arvalid) begin
        r_q <= '{id: arid, addr: araddr, len: arlen, cnt: 8'd0, size: arsize, burst: arburst,
                 resp: start_resp(ar_hit_c, arsize, arburst)};
      end else if (r_state_q == R_DATA && rready && !r_last_c) begin
        r_q.cnt  <= r_q.cnt + 8'd1;
        r_q.addr <= r_next_c;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_q <= '0;
    end else if (w_state_q == W_IDLE && awvalid) begin
      w_q <= '{id: awid, addr: awaddr, len: awlen, cnt: 8'd0, size: awsize, burst: awburst,
               resp: start_resp(aw_hit_c, awsize, awburst)};
    end else if (w_beat_c) begin
      w_q.resp <= resp_max(w_q.resp, w_beat_resp_c);
      if (!w_last_c) begin
        w_q.cnt  <= w_q.cnt + 8'd1;
        w_q.addr <= w_next_c;
      end
    end
  end

  always_comb begin
    rdata = r_data_q;
    if (r_fresh_q) rdata = sram_rdata;
    if (r_q.resp == RESP_DECERR) rdata = '0;
  end

  assign arready    = r_state_q == R_IDLE;
  assign rvalid     = r_state_q == R_DATA;
  assign rlast      = rvalid && r_last_c;
  assign rid        = r_q.id;
  assign rresp      = r_q.resp;
  assign awready    = w_state_q == W_IDLE;
  assign wready     = w_state_q == W_DATA;
  assign bvalid     = w_state_q == W_RESP;
  assign bid        = w_q.id;
  assign bresp      = w_q.resp;
  assign sram_en    = w_sram_c || r_sram_c;
  assign sram_we    = w_sram_c ? wstrb : 4'b0000;
  assign sram_addr  = w_beat_c ? ADDR_W'((w_q.addr - BASE) >> 2) : ADDR_W'((r_q.addr - BASE) >> 2);
  assign sram_wdata = wdata;

endmodule
